// File: rtl/decode_stage_if.sv
// Fetch/write-back/execute bundle around the decode stage.
// The slave modport is the stage's view; master is the surrounding pipeline.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            wb_en;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_ready;
    logic            out_valid;
    logic [2:0]      out_alu_op;
    logic            out_alu_alt;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_reg_write;
    logic            out_illegal;
    logic [RAW-1:0]  out_rs1;
    logic [RAW-1:0]  out_rs2;
    logic [RAW-1:0]  out_rd;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;

    modport master (
        output in_valid, instruction, wb_en, wb_rd, wb_data, flush, ex_ready,
        input  in_ready, out_valid, out_alu_op, out_alu_alt, out_imm, out_use_imm,
               out_reg_write, out_illegal, out_rs1, out_rs2, out_rd,
               out_rs1_data, out_rs2_data
    );

    modport slave (
        input  in_valid, instruction, wb_en, wb_rd, wb_data, flush, ex_ready,
        output in_ready, out_valid, out_alu_op, out_alu_alt, out_imm, out_use_imm,
               out_reg_write, out_illegal, out_rs1, out_rs2, out_rd,
               out_rs1_data, out_rs2_data
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: OP/OP-IMM decode, register read with write-back bypass,
// scoreboard stall and a single registered ID/EX slot.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic            alu_alt;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            reg_write;
        logic            illegal;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } id_ex_t;

    logic [NREG-1:0][XLEN-1:0] rf;
    logic [NREG-1:0]           pending;
    logic [NREG-1:0]           pending_nxt;
    id_ex_t                    dec;
    id_ex_t                    out_q;
    logic                      out_valid_q;
    logic                      is_op;
    logic                      is_opimm;
    logic                      legal;
    logic                      hazard;
    logic                      in_ready_c;
    logic                      fire;
    logic                      wb_we;
    logic                      kill_wr;

    function automatic logic [RAW-1:0] field(input logic [4:0] f);
        return RAW'(f);
    endfunction

    // Index 0 and indices beyond NREG have no storage and never track hazards.
    function automatic logic live_idx(input logic [RAW-1:0] idx);
        return (idx != '0) && (int'(idx) < NREG);
    endfunction

    function automatic logic [XLEN-1:0] rd_port(
        input logic [RAW-1:0]            idx,
        input logic [NREG-1:0][XLEN-1:0] regs,
        input logic                      we,
        input logic [RAW-1:0]            wr,
        input logic [XLEN-1:0]           wd
    );
        if (!live_idx(idx)) return '0;
        if (we && wr == idx) return wd;
        return regs[idx];
    endfunction

    // A write-back landing this cycle resolves the hazard for that register.
    function automatic logic pend(
        input logic [RAW-1:0]  idx,
        input logic [NREG-1:0] pnd,
        input logic            we,
        input logic [RAW-1:0]  wr
    );
        return live_idx(idx) && pnd[idx] && !(we && wr == idx);
    endfunction

    assign is_op    = bus.instruction[6:0] == OPC_OP;
    assign is_opimm = bus.instruction[6:0] == OPC_OPIMM;
    assign legal    = is_op || is_opimm;
    assign wb_we    = bus.wb_en && live_idx(bus.wb_rd);

    always_comb begin
        dec           = '0;
        dec.alu_op    = bus.instruction[14:12];
        dec.rs1       = field(bus.instruction[19:15]);
        dec.rs2       = field(bus.instruction[24:20]);
        dec.rd        = field(bus.instruction[11:7]);
        dec.use_imm   = is_opimm;
        dec.illegal   = !legal;
        dec.reg_write = legal && live_idx(dec.rd);
        dec.alu_alt   = (is_op || (is_opimm && bus.instruction[14:12] == 3'b101))
                        && bus.instruction[30];
        dec.imm       = is_op ? '0
                              : {{(XLEN-12){bus.instruction[31]}}, bus.instruction[31:20]};
        dec.rs1_data  = rd_port(dec.rs1, rf, bus.wb_en, bus.wb_rd, bus.wb_data);
        dec.rs2_data  = rd_port(dec.rs2, rf, bus.wb_en, bus.wb_rd, bus.wb_data);
    end

    always_comb begin
        hazard = 1'b0;
        if (legal) begin
            hazard = pend(dec.rs1, pending, bus.wb_en, bus.wb_rd)
                  || (is_op && pend(dec.rs2, pending, bus.wb_en, bus.wb_rd))
                  || (dec.reg_write && pend(dec.rd, pending, bus.wb_en, bus.wb_rd));
        end
    end

    assign in_ready_c   = (!out_valid_q || bus.ex_ready) && !hazard && !bus.flush;
    assign fire         = bus.in_valid && in_ready_c;
    assign kill_wr      = bus.flush && out_valid_q && out_q.reg_write;
    assign bus.in_ready = in_ready_c;

    // Clears first, then the issue-time set so a same-cycle set wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_we) pending_nxt[bus.wb_rd] = 1'b0;
        if (kill_wr) pending_nxt[out_q.rd] = 1'b0;
        if (fire && dec.reg_write) pending_nxt[dec.rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf          <= '0;
            pending     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wb_we) rf[bus.wb_rd] <= bus.wb_data;
            pending <= pending_nxt;
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (fire) begin
                out_valid_q <= 1'b1;
                out_q       <= dec;
            end else if (bus.ex_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_alu_op    = out_q.alu_op;
    assign bus.out_alu_alt   = out_q.alu_alt;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_use_imm   = out_q.use_imm;
    assign bus.out_reg_write = out_q.reg_write;
    assign bus.out_illegal   = out_q.illegal;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_rs1_data  = out_q.rs1_data;
    assign bus.out_rs2_data  = out_q.rs2_data;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: inputs change on negedge, outputs are
// checked on negedge (or 1ns later for the combinational in_ready).
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RAW  = 5;
    localparam logic [6:0] OPIMM = 7'b0010011;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    decode_stage_if #(.XLEN(XLEN), .RAW(RAW)) bus ();
    decode_stage #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = d;
        @(negedge clk);
        bus.wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.instruction = '0; bus.wb_en = 1'b0; bus.wb_rd = '0;
        bus.wb_data = '0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %h want 0", bus.out_valid); end
        n_cmp++; if (bus.out_imm !== 32'h0) begin n_bad++; $display("FAIL rst_imm: got %h want 0", bus.out_imm); end
        n_cmp++; if (bus.out_rs1_data !== 32'h0) begin n_bad++; $display("FAIL rst_rs1_data: got %h want 0", bus.out_rs1_data); end
        n_cmp++; if (bus.out_rd !== 5'd0) begin n_bad++; $display("FAIL rst_rd: got %h want 0", bus.out_rd); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %h want 1", bus.in_ready); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wb_write(5'd5, 32'h1234);
        wb_write(5'd0, 32'hFFFF);
        bus.in_valid = 1'b1; bus.instruction = r_op(7'h00, 5'd0, 5'd5, 3'b000, 5'd1);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %h want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %h want 1", bus.out_valid); end
        n_cmp++; if (bus.out_rs1_data !== 32'h1234) begin n_bad++; $display("FAIL basic_rs1_data: got %h want 1234", bus.out_rs1_data); end
        n_cmp++; if (bus.out_rs2_data !== 32'h0) begin n_bad++; $display("FAIL basic_rs2_data: got %h want 0", bus.out_rs2_data); end
        n_cmp++; if (bus.out_reg_write !== 1'b1) begin n_bad++; $display("FAIL basic_reg_write: got %h want 1", bus.out_reg_write); end
        n_cmp++; if (bus.out_rd !== 5'd1) begin n_bad++; $display("FAIL basic_rd: got %h want 1", bus.out_rd); end
        n_cmp++; if (bus.out_use_imm !== 1'b0) begin n_bad++; $display("FAIL basic_use_imm: got %h want 0", bus.out_use_imm); end
        wb_write(5'd1, 32'h0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got %h want 0", bus.out_valid); end
    endtask

    task automatic test_dependent();
        bus.in_valid = 1'b1; bus.instruction = i_op(12'hFFF, 5'd0, 3'b000, 5'd2, OPIMM);
        @(negedge clk);
        n_cmp++; if (bus.out_imm !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dep_imm: got %h want ffffffff", bus.out_imm); end
        n_cmp++; if (bus.out_use_imm !== 1'b1) begin n_bad++; $display("FAIL dep_use_imm: got %h want 1", bus.out_use_imm); end
        bus.instruction = r_op(7'h00, 5'd2, 5'd2, 3'b000, 5'd3);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL dep_stall0: got %h want 0", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL dep_bubble: got %h want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL dep_stall1: got %h want 0", bus.in_ready); end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL dep_wb_release: got %h want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.wb_en = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL dep_valid: got %h want 1", bus.out_valid); end
        n_cmp++; if (bus.out_rs1_data !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dep_rs1_bypass: got %h want ffffffff", bus.out_rs1_data); end
        n_cmp++; if (bus.out_rs2_data !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dep_rs2_bypass: got %h want ffffffff", bus.out_rs2_data); end
        n_cmp++; if (bus.out_rd !== 5'd3) begin n_bad++; $display("FAIL dep_rd: got %h want 3", bus.out_rd); end
        wb_write(5'd3, 32'h0);
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1; bus.instruction = i_op(12'h005, 5'd0, 3'b000, 5'd7, OPIMM);
        @(negedge clk);
        bus.ex_ready = 1'b0; bus.instruction = i_op(12'h009, 5'd0, 3'b000, 5'd8, OPIMM);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %h want 0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'h5 || bus.out_rd !== 5'd7)
                begin n_bad++; $display("FAIL bp_hold%0d: got v=%h imm=%h rd=%h want v=1 imm=5 rd=7", i, bus.out_valid, bus.out_imm, bus.out_rd); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall%0d: got %h want 0", i, bus.in_ready); end
        end
        bus.ex_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %h want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'h9 || bus.out_rd !== 5'd8)
            begin n_bad++; $display("FAIL bp_next: got v=%h imm=%h rd=%h want v=1 imm=9 rd=8", bus.out_valid, bus.out_imm, bus.out_rd); end
        wb_write(5'd7, 32'h0);
        wb_write(5'd8, 32'h0);
    endtask

    task automatic test_flush();
        bus.in_valid = 1'b1; bus.ex_ready = 1'b0; bus.instruction = i_op(12'h044, 5'd0, 3'b000, 5'd4, OPIMM);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_reg_write !== 1'b1) begin n_bad++; $display("FAIL fl_loaded: got v=%h rw=%h want 1 1", bus.out_valid, bus.out_reg_write); end
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_ready: got %h want 0", bus.in_ready); end
        @(negedge clk);
        bus.flush = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_killed: got %h want 0", bus.out_valid); end
        bus.ex_ready = 1'b1; bus.in_valid = 1'b1; bus.instruction = r_op(7'h00, 5'd4, 5'd4, 3'b000, 5'd9);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL fl_no_stall: got %h want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_rs1 !== 5'd4 || bus.out_rd !== 5'd9)
            begin n_bad++; $display("FAIL fl_follow: got v=%h rs1=%h rd=%h want 1 4 9", bus.out_valid, bus.out_rs1, bus.out_rd); end
        wb_write(5'd9, 32'h0);
    endtask

    task automatic test_alt_illegal();
        bus.in_valid = 1'b1; bus.instruction = i_op(12'h403, 5'd6, 3'b101, 5'd6, OPIMM);
        @(negedge clk);
        n_cmp++; if (bus.out_alu_alt !== 1'b1 || bus.out_alu_op !== 3'd5) begin n_bad++; $display("FAIL srai_alt: got alt=%h op=%h want 1 5", bus.out_alu_alt, bus.out_alu_op); end
        n_cmp++; if (bus.out_imm !== 32'h403 || bus.out_use_imm !== 1'b1) begin n_bad++; $display("FAIL srai_imm: got imm=%h ui=%h want 403 1", bus.out_imm, bus.out_use_imm); end
        bus.instruction = i_op(12'h400, 5'd0, 3'b000, 5'd10, OPIMM);
        @(negedge clk);
        n_cmp++; if (bus.out_alu_alt !== 1'b0 || bus.out_imm !== 32'h400) begin n_bad++; $display("FAIL addi_alt: got alt=%h imm=%h want 0 400", bus.out_alu_alt, bus.out_imm); end
        bus.instruction = r_op(7'h20, 5'd0, 5'd0, 3'b000, 5'd11);
        @(negedge clk);
        n_cmp++; if (bus.out_alu_alt !== 1'b1 || bus.out_imm !== 32'h0 || bus.out_use_imm !== 1'b0)
            begin n_bad++; $display("FAIL sub_alt: got alt=%h imm=%h ui=%h want 1 0 0", bus.out_alu_alt, bus.out_imm, bus.out_use_imm); end
        bus.instruction = i_op(12'h000, 5'd0, 3'b010, 5'd12, 7'b0000011);
        @(negedge clk);
        n_cmp++; if (bus.out_illegal !== 1'b1 || bus.out_reg_write !== 1'b0 || bus.out_valid !== 1'b1)
            begin n_bad++; $display("FAIL illegal: got ill=%h rw=%h v=%h want 1 0 1", bus.out_illegal, bus.out_reg_write, bus.out_valid); end
        bus.instruction = r_op(7'h00, 5'd12, 5'd12, 3'b000, 5'd13);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_no_stall: got %h want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_rs1 !== 5'd12 || bus.out_illegal !== 1'b0)
            begin n_bad++; $display("FAIL illegal_follow: got v=%h rs1=%h ill=%h want 1 c 0", bus.out_valid, bus.out_rs1, bus.out_illegal); end
        wb_write(5'd6, 32'h0);
        wb_write(5'd10, 32'h0);
        wb_write(5'd11, 32'h0);
        wb_write(5'd13, 32'h0);
    endtask

    task automatic test_reset_mid();
        wb_write(5'd5, 32'h1234);
        bus.in_valid = 1'b1; bus.instruction = i_op(12'h001, 5'd0, 3'b000, 5'd14, OPIMM);
        @(negedge clk);
        bus.instruction = r_op(7'h00, 5'd5, 5'd14, 3'b000, 5'd15);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rm_stall: got %h want 0", bus.in_ready); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_rd !== 5'd0) begin n_bad++; $display("FAIL rm_out: got v=%h rd=%h want 0 0", bus.out_valid, bus.out_rd); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_sb_clear: got %h want 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %h want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_rs1 !== 5'd14 || bus.out_rd !== 5'd15)
            begin n_bad++; $display("FAIL rm_issue: got v=%h rs1=%h rd=%h want 1 e f", bus.out_valid, bus.out_rs1, bus.out_rd); end
        n_cmp++; if (bus.out_rs2_data !== 32'h0) begin n_bad++; $display("FAIL rm_rf_cleared: got %h want 0", bus.out_rs2_data); end
        wb_write(5'd15, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_dependent();
        test_back_to_back();
        test_flush();
        test_alt_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
